// File: rtl/scan_display_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display.
// Walks a digit index through the external nibble mux, decodes the returned
// nibble, and drives one-hot digit enables with a blanking window at the
// start of every digit slot so the previous digit's segments never ghost.
module scan_display_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 16,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] dig_mask,
  input  logic [7:0] dp_in,
  input  logic [3:0] data_in,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] dig,
  output logic       frame_tick
);

  localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic          slot_end;

  // Active-high next values; polarity is applied only at the output flops.
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [7:0] dig_nxt;
  logic       tick_nxt;

  // Nibble to segment decode, active-high gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end     = (div_cnt == DIV_LAST);
  // The select is the index register itself, so it moves on the same edge.
  assign {s2, s1, s0} = idx;

  // Slot divider and digit index; both freeze while scanning is disabled.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      div_cnt <= '0;
      idx     <= 3'd0;
    end else if (en) begin
      if (slot_end) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Next display values from the current slot phase, mask and mux data.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    seg_nxt  = '0;
    dp_nxt   = 1'b0;
    dig_nxt  = '0;
    tick_nxt = 1'b0;
    if (en) begin
      tick_nxt = slot_end && (idx == 3'd7);
      if (dig_mask[idx]) begin
        seg_nxt = hex7(data_in);
        dp_nxt  = dp_in[idx];
        if (div_cnt >= BLANK_END) begin
          dig_nxt[idx] = 1'b1;
        end
      end
    end
  end

  // Output flops with polarity applied; reset leaves the display dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= {7{SEG_ACT_LOW}};
      dp         <= SEG_ACT_LOW;
      dig        <= {8{DIG_ACT_LOW}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ {7{SEG_ACT_LOW}};
      dp         <= dp_nxt ^ SEG_ACT_LOW;
      dig        <= dig_nxt ^ {8{DIG_ACT_LOW}};
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl with CLK_DIV=4, BLANK_CYC=1,
// active-low segments and digits. A reference model tracks the scan
// position as a single frame counter and predicts every registered output.
module tb_scan_display_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] dig_mask;
  logic [7:0] dp_in;
  logic [3:0] data_in;
  logic       s2, s1, s0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] dig;
  logic       frame_tick;

  int checks   = 0;
  int failures = 0;

  logic [3:0] mux_data [8];
  logic [6:0] hex_tab  [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: position within the 32-cycle frame plus predicted outputs.
  int         pos = 0;
  logic [7:0] e_dig  = 8'hFF;
  logic [6:0] e_seg  = 7'h7F;
  logic       e_dp   = 1'b1;
  logic       e_tick = 1'b0;
  bit         checking_on = 1'b0;
  int         tick_count = 0;

  always #5 clk = ~clk;

  // External 32-to-4 mux: returns the nibble of the selected digit.
  assign data_in = mux_data[{s2, s1, s0}];

  scan_display_ctrl #(
    .CLK_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dig_mask(dig_mask), .dp_in(dp_in),
    .data_in(data_in), .s2(s2), .s1(s1), .s0(s0), .seg(seg), .dp(dp),
    .dig(dig), .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: digit = pos/4, slot cycle = pos%4, one blank cycle per slot.
  always @(posedge clk) begin
    int d_idx, d_cyc;
    if (rst) begin
      pos = 0; e_dig = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    end else if (en) begin
      d_idx  = pos / 4;
      d_cyc  = pos % 4;
      e_tick = (pos == 31);
      e_dig  = (dig_mask[d_idx] && d_cyc >= 1) ? ~(8'b1 << d_idx) : 8'hFF;
      e_seg  = dig_mask[d_idx] ? ~hex_tab[mux_data[d_idx]] : 7'h7F;
      e_dp   = dig_mask[d_idx] ? ~dp_in[d_idx] : 1'b1;
      pos    = (pos + 1) % 32;
    end else begin
      e_dig = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (checking_on) begin
      check("sel", {29'd0, s2, s1, s0}, pos / 4);
      check("dig", dig, e_dig);
      check("seg", seg, e_seg);
      check("dp", dp, e_dp);
      check("frame_tick", frame_tick, e_tick);
      check("dig_onehot0", $onehot0(~dig), 1);
      if (frame_tick === 1'b1) tick_count++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until the model reaches a given frame position (bounded).
  task automatic wait_pos(input int target, input string tag);
    int budget = 200;
    while (pos != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_reached"}, pos, target);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dig_mask = 8'hFF; dp_in = 8'h00;
    for (int i = 0; i < 8; i++) mux_data[i] = 4'(i);

    // 1. Reset then first slot
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking_on = 1'b1;
    check("rst_dig", dig, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_sel", {s2, s1, s0}, 3'b000);
    check("rst_tick", frame_tick, 1'b0);
    cycles(2);
    check("first_dig", dig, 8'hFE);
    check("first_seg", seg, 7'h40);

    // 2. Free run, full mask: two frames -> exactly two ticks
    tick_count = 0;
    cycles(64);
    check("tick_count", tick_count, 2);

    // 3. Alternate digits masked
    dig_mask = 8'hAA;
    cycles(40);
    dig_mask = 8'hFF;

    // 4. Sweep every nibble through the decoder, dp on digit 0 only
    dp_in = 8'h01;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) mux_data[i] = 4'((f * 8 + i) % 16);
      cycles(32);
    end

    // 5. Freeze at idx 5, slot cycle 2
    wait_pos(22, "freeze");
    en = 1'b0;
    cycles(10);
    check("freeze_dig", dig, 8'hFF);
    check("freeze_sel", {s2, s1, s0}, 3'b101);
    en = 1'b1;
    cycles(2);
    check("resume_sel", {s2, s1, s0}, 3'b110);

    // 6. Reset mid-slot at idx 6, slot cycle 3
    wait_pos(27, "midrst");
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("midrst_sel", {s2, s1, s0}, 3'b000);
    check("midrst_dig", dig, 8'hFF);
    check("midrst_tick", frame_tick, 1'b0);

    // Randomized run: masks, dp, mux contents and enable all wander
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) dig_mask = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dp_in    = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mux_data[$urandom_range(0, 7)] = 4'($urandom);
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycles(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    cycles(2);

    checking_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
